encode_4x2_serial: RTL
======================

# encode_4x2_serial

Sequential 4-to-2 encoder, the counterpart of the team's 2x4 decoder. It accepts a 4-bit event vector (one or more bits set) over a valid/ready handshake and emits the 2-bit binary index of each set bit, one index per accepted output beat. Indices are emitted in ascending order, and the final beat of a vector is flagged with `out_last`. It sits between the request/event logic and any consumer that takes binary-coded indices, such as a 2x4 decoder downstream or a logging path.

## Interface
- `WIDTH`, default 4: number of input lines. Fixed at 4 for this block; other values are unsupported.
- `IDX_W`, default 2: output index width. Must equal log2(`WIDTH`).

- `clk`  input  1  single clock; all state updates on the rising edge.
- `rst`  input  1  asynchronous, active-high reset.
- `in_valid`  input  1  `in_vec` is valid this cycle.
- `in_ready`  output  1  block can accept a vector this cycle.
- `in_vec`  input  `WIDTH`  event vector; bit k set means "emit index k".
- `out_valid`  output  1  `out_idx` and `out_last` are valid.
- `out_ready`  input  1  consumer accepts the current beat.
- `out_idx`  output  `IDX_W`  binary index of the lowest pending set bit.
- `out_last`  output  1  this beat is the last index of the current vector.

## Operation
- Storage: a `WIDTH`-bit `pending` register and a 1-bit state, IDLE or EMIT.
- IDLE:
  - `in_ready`=1, `out_valid`=0.
  - On `in_valid`&`in_ready` with `in_vec`≠0: `pending`<=`in_vec`, go to EMIT.
  - On `in_valid`&`in_ready` with `in_vec`==0: the vector is consumed and dropped. No output is produced and the state stays IDLE.
- EMIT:
  - `in_ready`=0, `out_valid`=1.
  - `out_idx` = index of the lowest set bit of `pending` (priority to bit 0).
  - `out_last` = 1 when `pending` has exactly one bit set.
  - On `out_valid`&`out_ready`: clear that bit in `pending`.
  - If `out_last` was 1 on that beat, go to IDLE (`pending` becomes 0).
- When `out_valid`=0, `out_idx`=0 and `out_last`=0. These are defined values, not don't-cares.
- While `out_valid`=1 and `out_ready`=0, `out_idx`/`out_last` are held stable and `pending` is unchanged.
- `in_vec` is ignored whenever `in_ready`=0, regardless of `in_valid`.
- No input is accepted in the same cycle as the final output beat. `in_ready` first rises the cycle after the last beat.
- Reset (asserted at any time, including mid-EMIT):
  - Immediately: state=IDLE, `pending`=0.
  - Outputs: `in_ready`=1 (0 is also acceptable while `rst` is held, but 1 is required after release), `out_valid`=0, `out_idx`=0, `out_last`=0.
  - Any partially emitted vector is discarded. No beats resume after `rst` deasserts.

## Timing
- Input acceptance at edge N gives `out_valid`=1 in the cycle following edge N.
- With `out_ready` held at 1, a vector with k set bits produces k beats on k consecutive cycles.
- `in_ready` returns to 1 in the cycle after the last beat.
- Sustained throughput: k+1 cycles per vector with k set bits; 1 cycle for a zero vector.
- All outputs are derived only from registered state (state, `pending`). There is no combinational path from any input to any output.

## Test plan
- Reset: assert `rst` asynchronously between edges. Required: `out_valid`=0, `out_idx`=0, `out_last`=0 at once, and `in_ready`=1 after release.
- Single bit: `in_vec`=4'b0100, `out_ready`=1. Required: one beat with `out_idx`=2, `out_last`=1 in the cycle after acceptance, then `in_ready`=1 the following cycle.
- Multi-bit: `in_vec`=4'b1011, `out_ready`=1. Required:
  - beats (`idx`,`last`) = (0,0), (1,0), (3,1) on three consecutive cycles;
  - `in_ready`=0 throughout those three cycles and `in_vec` changes ignored;
  - `in_ready`=1 on the fourth cycle.
- Backpressure: `in_vec`=4'b0110, `out_ready`=0 for 3 cycles then 1. Required:
  - `out_idx`=1, `out_last`=0 held stable for all stalled cycles;
  - then beats (1,0) and (2,1).
- Zero vector: `in_vec`=4'b0000 with `in_valid`=1 for one cycle. Required: consumed, `out_valid` stays 0, `in_ready` stays 1. A following 4'b1000 then produces (3,1).
- Reset mid-operation: `in_vec`=4'b1111, `out_ready`=1. After beats 0 and 1, assert `rst`. Required:
  - `out_valid`=0 immediately, with no beats 2 or 3 ever appearing;
  - after release, a new 4'b0001 yields (0,1).

Source files
------------

// File: rtl/encode_4x2_serial.sv
// Purpose : serial 4-to-2 encoder; emits the binary index of each set bit of an
//           accepted event vector, lowest bit first, last beat flagged.
// Latency : first beat the cycle after acceptance; k beats for k set bits, in_ready
//           returns the cycle after the final beat.
// Backpressure: out_ready=0 holds out_idx/out_last and pending; input is refused
//           (in_ready=0) for the whole time a vector is being emitted.
//
// Ports:
//   clk, rst             clock, asynchronous active-high reset
//   in_valid/in_ready    input handshake, in_vec = event vector (bit k -> index k)
//   out_valid/out_ready  output handshake, out_idx = index, out_last = final beat
module encode_4x2_serial #(
   parameter int WIDTH = 4,
   parameter int IDX_W = 2
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] in_vec,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [IDX_W-1:0] out_idx,
   output logic             out_last
);

   typedef enum logic {
      IDLE = 1'b0,
      EMIT = 1'b1
   } state_t;

   state_t           state;
   state_t           state_nxt;
   logic [WIDTH-1:0] pending;
   logic [WIDTH-1:0] pending_nxt;
   logic [WIDTH-1:0] lsb_mask;
   logic [IDX_W-1:0] low_idx;
   logic             one_left;

   // Isolate the lowest set bit of pending; two's-complement trick.
   assign lsb_mask = pending & (~pending + WIDTH'(1));
   // Exactly one bit set: clearing the lowest set bit leaves nothing.
   assign one_left = (pending != '0) && ((pending & ~lsb_mask) == '0);

   // Priority encoder, bit 0 wins: scan from the top so the lowest hit is kept.
   always_comb begin
      low_idx = '0;
      for (int k = WIDTH - 1; k >= 0; k--) begin
         if (pending[k]) begin
            low_idx = IDX_W'(k);
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state   <= IDLE;
         pending <= '0;
      end else begin
         state   <= state_nxt;
         pending <= pending_nxt;
      end
   end

   // Outputs depend only on state and pending, never directly on inputs.
   always_comb begin
      state_nxt   = state;
      pending_nxt = pending;
      in_ready    = 1'b0;
      out_valid   = 1'b0;
      out_idx     = '0;
      out_last    = 1'b0;

      case (state)
         IDLE: begin
            in_ready = 1'b1;
            // A zero vector is accepted and silently dropped.
            if (in_valid && (in_vec != '0)) begin
               pending_nxt = in_vec;
               state_nxt   = EMIT;
            end
         end
         EMIT: begin
            out_valid = 1'b1;
            out_idx   = low_idx;
            out_last  = one_left;
            if (out_ready) begin
               pending_nxt = pending & ~lsb_mask;
               if (one_left) begin
                  state_nxt = IDLE;
               end
            end
         end
         default: begin
            state_nxt   = IDLE;
            pending_nxt = '0;
         end
      endcase
   end

endmodule
